// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO pair.
// Operands are reduced to magnitudes at launch, processed one bit per cycle
// (shift-add for multiply, restoring shift-subtract for divide), and the
// result signs are applied in a final FIX cycle that also commits HI/LO.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // op[1] selects divide, op[0] selects the unsigned variant.
    localparam int CW = $clog2(ITER + 1);

    state_t               state;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;      // raw dividend, returned as HI on divide by zero
    logic [WIDTH-1:0]     mag_a;    // multiplicand magnitude
    logic [WIDTH-1:0]     mag_b;    // divisor magnitude
    logic [2*WIDTH-1:0]   prod;     // {partial sum, remaining multiplier bits}
    logic [WIDTH:0]       rem;      // partial remainder, one guard bit
    logic [WIDTH-1:0]     quo;      // dividend bits shift out, quotient bits shift in
    logic                 sign_q;   // product sign or quotient sign
    logic                 rsign_q;  // remainder sign (dividend sign)
    logic [CW-1:0]        cnt;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH:0]       div_rem_next;
    logic [WIDTH-1:0]     div_quo_next;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     quo_fixed, rem_fixed;

    // Next-step datapath values for launch, RUN iterations and FIX sign correction.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        abs_a        = a;
        abs_b        = b;
        if (!op[0] && a[WIDTH-1]) abs_a = -a;
        if (!op[0] && b[WIDTH-1]) abs_b = -b;

        mul_sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
        mul_next     = {mul_sum, prod[WIDTH-1:1]};

        div_shift    = {rem[WIDTH-1:0], quo[WIDTH-1]};
        div_ge       = (div_shift >= {1'b0, mag_b});
        div_rem_next = div_ge ? (div_shift - {1'b0, mag_b}) : div_shift;
        div_quo_next = {quo[WIDTH-2:0], div_ge};

        prod_fixed   = sign_q  ? -prod           : prod;
        quo_fixed    = sign_q  ? -quo            : quo;
        rem_fixed    = rsign_q ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    // Control FSM with registered busy/done and the HI/LO architectural state.
    // NOTE: sequential state uses non-blocking assignments; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            prod    <= '0;
            rem     <= '0;
            quo     <= '0;
            sign_q  <= 1'b0;
            rsign_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        mag_a   <= abs_a;
                        mag_b   <= abs_b;
                        prod    <= {{WIDTH{1'b0}}, abs_b};
                        rem     <= '0;
                        quo     <= abs_a;
                        sign_q  <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rsign_q <= !op[0] && a[WIDTH-1];
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        if (hi_wr) hi <= wr_data;
                        if (lo_wr) lo <= wr_data;
                    end
                end

                S_RUN: begin
                    if (op_q[1]) begin
                        rem <= div_rem_next;
                        quo <= div_quo_next;
                    end else begin
                        prod <= mul_next;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) state <= S_FIX;
                end

                S_FIX: begin
                    if (!op_q[1]) begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end else if (mag_b == '0) begin
                        hi <= a_q;
                        lo <= '1;
                    end else begin
                        hi <= rem_fixed;
                        lo <= quo_fixed;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the MIPS execute stage.
- Sits directly downstream of the register file: consumes the two read-port operands (rs, rt) and holds the architectural HI/LO registers.
- Supports MULT, MULTU, DIV, DIVU, MTHI and MTLO. MFHI/MFLO read the hi/lo outputs combinationally.
- Stalls the pipeline through busy until the result is committed.

Parameters:
- WIDTH, 32, operand/HI/LO width. Only 32 is required to be supported.
- ITER, 32, iteration cycles in RUN. Must equal WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch an operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  32  rs operand (multiplicand / dividend).
- b  input  32  rt operand (multiplier / divisor).
- hi_wr  input  1  MTHI strobe.
- lo_wr  input  1  MTLO strobe.
- wr_data  input  32  data for MTHI/MTLO.
- busy  output  1  high while an operation is in progress; the pipeline stalls on MFHI/MFLO/new start.
- done  output  1  one-cycle pulse in the cycle after HI/LO are committed.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, all internal datapath registers 0. Reset mid-operation aborts it; HI/LO read 0 afterwards.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> FIX after ITER iterations.
  - FIX -> IDLE, committing HI/LO.
- Launch edge E0 (IDLE, start=1):
  - Latch op.
  - Latch |a| and |b| (magnitudes for signed ops, raw values for unsigned ops).
  - Latch result signs:
    - MULT: sign = a[31]^b[31].
    - DIV: quotient sign = a[31]^b[31]; remainder sign = a[31].
  - busy=1 from E0.
- RUN, edges E1..E32, one bit per edge:
  - Multiply: shift-add on a 64-bit product register.
  - Divide: restoring shift-subtract on a 33-bit partial remainder, producing 32 quotient bits.
- FIX, edge E33:
  - Apply sign correction (two's complement negate) where the latched sign is 1.
  - Write hi/lo. Multiply: {hi,lo}=64-bit product. Divide: lo=quotient, hi=remainder.
  - busy=0 and done=1 at E33. done drops at E34.
- Total latency: done first visible 33 cycles after the launch edge. hi/lo hold new values while done=1 and thereafter.
- Divide by zero (b=0, DIV or DIVU): full latency still taken; lo=32'hFFFFFFFF, hi=a (unmodified dividend, no sign fixup).
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. This falls out of magnitude arithmetic; no special case is needed.
- MULT of 0x80000000 * 0x80000000: {hi,lo}=0x40000000_00000000. Magnitudes must be handled as 33-bit unsigned internally or via 32-bit unsigned with a separate sign.
- start while busy: ignored; no queueing.
- hi_wr/lo_wr:
  - Honoured only in IDLE with start=0, taking effect at the next edge.
  - Ignored while busy.
  - If start=1 in the same cycle, start wins and the writes are dropped.
  - hi_wr and lo_wr together write both registers.
- hi/lo are not modified during RUN; they still show the previous results until E33.
- done is never asserted without a preceding start. A start at the edge where done is high (IDLE again) is accepted.

Test Plan:
- Multiply, signed and unsigned:
  - MULT a=0xFFFFFFFD (-3), b=5 -> after 33 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
  - MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - MULT a=b=0x80000000 -> hi=0x40000000, lo=0.
- Signed divide:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x64, done after 33 cycles.
- Move and contention rules:
  - hi_wr=1, wr_data=0x12345678 in IDLE -> hi=0x12345678 next cycle.
  - hi_wr pulsed during busy -> hi unchanged.
  - start+lo_wr in the same cycle -> lo_wr dropped.
  - start pulsed mid-RUN -> ignored; one done only.
- Reset mid-run: start MULTU 3*4, assert rst_n=0 at cycle 10 -> busy=0, done=0, hi=lo=0 immediately. After release, a new MULTU 3*4 gives lo=12, hi=0.
